// File: rtl/riscv_pkg.sv
// Shared RV32M divider definitions: operation encodings, FSM states, width.
package riscv_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIN  = 2'b10
    } state_e;

    // DIV and REM treat operands as two's complement; the U variants do not.
    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    // REM and REMU return the remainder; DIV and DIVU return the quotient.
    function automatic logic op_is_rem(input logic [1:0] op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/div_sign_fix.sv
// Final sign correction of the magnitude quotient/remainder into the RV32M result.
module div_sign_fix #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] rem,
    input  logic            sign1,
    input  logic            sign2,
    input  logic [1:0]      op,
    output logic [XLEN-1:0] result
);
    import riscv_pkg::*;

    // Sign flags are only ever set for signed ops, but gate again so a stray
    // flag can never corrupt an unsigned result.
    always_comb begin
        result = quo;
        if (op_is_rem(op)) begin
            result = (op_is_signed(op) && sign1) ? (~rem + 1'b1) : rem;
        end else begin
            result = (op_is_signed(op) && (sign1 ^ sign2)) ? (~quo + 1'b1) : quo;
        end
    end

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divide/remainder unit for RV32M with start/busy/done handshake.
module div_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    import riscv_pkg::*;

    localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

    state_e            state;
    logic [1:0]        op_q;
    logic [XLEN-1:0]   dvd;        // dividend magnitude, shifts into the quotient
    logic [XLEN-1:0]   dsr;        // divisor magnitude
    logic [XLEN:0]     rem;        // extra bit holds the trial-subtract borrow
    logic [CNT_W-1:0]  cnt;
    logic              sign1;
    logic              sign2;
    logic              fast;
    logic [XLEN-1:0]   fast_res;

    logic              in_signed;
    logic [XLEN-1:0]   abs1;
    logic [XLEN-1:0]   abs2;
    logic [XLEN:0]     rem_shift;
    logic [XLEN:0]     diff;
    logic [XLEN-1:0]   fixed;

    assign busy      = (state != IDLE);
    assign in_signed = op_is_signed(op);
    // Magnitude of 0x80000000 wraps back to 0x80000000, which is correct as unsigned.
    assign abs1      = (in_signed && rs1[XLEN-1]) ? (~rs1 + 1'b1) : rs1;
    assign abs2      = (in_signed && rs2[XLEN-1]) ? (~rs2 + 1'b1) : rs2;
    assign rem_shift = {rem[XLEN-1:0], dvd[XLEN-1]};
    assign diff      = rem_shift - {1'b0, dsr};

    div_sign_fix #(.XLEN(XLEN)) u_sign_fix (
        .quo    (dvd),
        .rem    (rem[XLEN-1:0]),
        .sign1  (sign1),
        .sign2  (sign2),
        .op     (op_q),
        .result (fixed)
    );

    // Control FSM and datapath: accept, iterate one quotient bit per edge, finish.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            done     <= 1'b0;
            result   <= '0;
            op_q     <= '0;
            dvd      <= '0;
            dsr      <= '0;
            rem      <= '0;
            cnt      <= '0;
            sign1    <= 1'b0;
            sign2    <= 1'b0;
            fast     <= 1'b0;
            fast_res <= '0;
        end else if (flush) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q  <= op;
                        dvd   <= abs1;
                        dsr   <= abs2;
                        sign1 <= in_signed && rs1[XLEN-1];
                        sign2 <= in_signed && rs2[XLEN-1];
                        rem   <= '0;
                        cnt   <= '0;
                        if (rs2 == '0) begin
                            fast     <= 1'b1;
                            fast_res <= op_is_rem(op) ? rs1 : '1;
                            state    <= FIN;
                        end else if (in_signed && (rs1 == MIN_NEG) && (rs2 == '1)) begin
                            fast     <= 1'b1;
                            fast_res <= op_is_rem(op) ? '0 : MIN_NEG;
                            state    <= FIN;
                        end else begin
                            fast     <= 1'b0;
                            state    <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (!diff[XLEN]) begin
                        rem <= diff;
                        dvd <= {dvd[XLEN-2:0], 1'b1};
                    end else begin
                        rem <= rem_shift;
                        dvd <= {dvd[XLEN-2:0], 1'b0};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        state <= FIN;
                    end
                end
                FIN: begin
                    result <= fast ? fast_res : fixed;
                    done   <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit with an expected-result scoreboard.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        flush;
    logic [1:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_res = '0;
    logic        seen;

    localparam logic [1:0] DIV  = 2'b00;
    localparam logic [1:0] DIVU = 2'b01;
    localparam logic [1:0] REM  = 2'b10;
    localparam logic [1:0] REMU = 2'b11;

    div_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .flush  (flush),
        .op     (op),
        .rs1    (rs1),
        .rs2    (rs2),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one start edge; inputs are scrambled right after to prove capture.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] e, input bit push);
        if (push) exp_q.push_back(e);
        op    = o;
        rs1   = a;
        rs2   = b;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        op    = 2'($urandom);
        rs1   = $urandom;
        rs2   = $urandom;
    endtask

    // Wait for done counting edges after the accepting edge; compare latency and result.
    task automatic wait_done(input string tag, input int base, input int lat, input int exp_busy);
        int n  = base;
        int bc = 0;
        logic [31:0] e;
        while (!done && n < base + 200) begin
            if (busy) bc++;
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_lat"}, 32'(n), 32'(lat));
        if (exp_busy >= 0) chk({tag, "_busycyc"}, 32'(bc), 32'(exp_busy));
        e = exp_q.pop_front();
        chk({tag, "_res"}, result, e);
        last_res = e;
    endtask

    // Check the done pulse drops after one cycle while result holds.
    task automatic after_done(input string tag);
        @(posedge clk); #1;
        chk({tag, "_pulse"}, 32'(done), 32'd0);
        chk({tag, "_hold"}, result, last_res);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; flush = 1'b0; op = '0; rs1 = '0; rs2 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_res", result, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        issue(DIVU, 32'd100, 32'd7, 32'd14, 1);
        wait_done("divu_100_7", 0, 33, 33);
        after_done("divu_100_7");
        issue(REMU, 32'd100, 32'd7, 32'd2, 1);
        wait_done("remu_100_7", 0, 33, 33);

        issue(DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1);
        wait_done("div_m7_2", 0, 33, -1);
        issue(REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1);
        wait_done("rem_m7_2", 0, 33, -1);
        issue(DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1);
        wait_done("div_7_m2", 0, 33, -1);
        issue(REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 1);
        wait_done("rem_7_m2", 0, 33, -1);
        issue(DIV, 32'h8000_0000, 32'd1, 32'h8000_0000, 1);
        wait_done("div_min_1", 0, 33, -1);
        issue(REM, 32'h8000_0000, 32'd3, 32'hFFFF_FFFE, 1);
        wait_done("rem_min_3", 0, 33, -1);
        issue(DIVU, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 1);
        wait_done("divu_max_16", 0, 33, -1);

        issue(DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        wait_done("div_by0", 0, 1, 1);
        after_done("div_by0");
        issue(REMU, 32'd5, 32'd0, 32'd5, 1);
        wait_done("remu_by0", 0, 1, 1);
        issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        wait_done("div_ovf", 0, 1, 1);
        issue(REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
        wait_done("rem_ovf", 0, 1, 1);

        // Start while busy at edge k+5 must be ignored.
        issue(DIVU, 32'd1000, 32'd10, 32'd100, 1);
        repeat (4) begin @(posedge clk); #1; end
        op = DIVU; rs1 = 32'd9; rs2 = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("ignore_start", 5, 33, -1);
        // Back-to-back issue in the done cycle.
        issue(REMU, 32'd1000, 32'd7, 32'd6, 1);
        chk("b2b_busy", 32'(busy), 32'd1);
        chk("b2b_done_drop", 32'(done), 32'd0);
        wait_done("b2b", 0, 33, 33);

        // Flush at k+10 discards the operation and keeps the old result.
        issue(DIVU, 32'd50, 32'd5, 32'd10, 0);
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_done", 32'(done), 32'd0);
        chk("flush_res", result, last_res);
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (done) seen = 1'b1; end
        chk("flush_nodone", 32'(seen), 32'd0);

        // Reset at k+10 discards the operation and clears the result.
        issue(DIVU, 32'd50, 32'd5, 32'd10, 0);
        repeat (9) begin @(posedge clk); #1; end
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_res", result, 32'd0);
        last_res = '0;
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (done) seen = 1'b1; end
        chk("midrst_nodone", 32'(seen), 32'd0);

        // Flush wins over start while idle.
        op = DIVU; rs1 = 32'd8; rs2 = 32'd0; start = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        chk("flush_start_busy", 32'(busy), 32'd0);
        seen = 1'b0;
        repeat (5) begin @(posedge clk); #1; if (done) seen = 1'b1; end
        chk("flush_start_nodone", 32'(seen), 32'd0);
        chk("flush_start_res", result, last_res);

        // Normal operation afterwards.
        issue(DIVU, 32'd12345, 32'd123, 32'd100, 1);
        wait_done("final", 0, 33, 33);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
Iterative RV32M divide/remainder unit that sits directly downstream of the register file.
- Consumes RD1 and RD2 as rs1 and rs2.
- Produces a 32-bit result for the WD3 write-back path.
- Uses a radix-2 restoring algorithm: one quotient bit per clock, plus a sign fix-up cycle.
- Handshake is start/busy/done, so the control path stalls write-back (WE) until done.

Parameters:
XLEN, 32, operand/result width. Only 32 is supported.
CNT_W, 6, width of the iteration counter. Must satisfy 2^CNT_W > XLEN.

Ports:
clk  in  1  system clock, all state updates on posedge
rst  in  1  synchronous reset, active-low
start  in  1  request a new operation; sampled only when idle
flush  in  1  abort any in-flight operation (pipeline kill)
op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
rs1  in  XLEN  dividend (from RD1)
rs2  in  XLEN  divisor (from RD2)
busy  out  1  operation in progress
done  out  1  one-cycle pulse, result valid
result  out  XLEN  quotient or remainder; held until the next accepted start

Behaviour:
- Reset (rst==0 at a posedge): state=IDLE, busy=0, done=0, result=0, counter=0, internal registers=0. Applies mid-operation; the in-flight operation is discarded with no done.
- States: IDLE, CALC, FIN. busy = (state != IDLE).
- IDLE, start=1, flush=0 at edge k:
  - Latch op.
  - Latch |rs1| and |rs2| (absolute value for signed ops, raw value for unsigned).
  - Latch the sign flags.
  - Clear the partial remainder and counter.
  - Clear done.
- Fast path, evaluated at edge k:
  - rs2==0: next state FIN. DIV/DIVU result = 0xFFFFFFFF; REM/REMU result = rs1 unmodified.
  - Signed overflow (op DIV or REM, rs1==0x80000000, rs2==0xFFFFFFFF): next state FIN. DIV result = 0x80000000; REM result = 0.
  - Otherwise: next state CALC.
- CALC: one restoring step per edge.
  - Shift the remainder left, bringing in the dividend MSB.
  - Trial-subtract the divisor using an XLEN+1-bit subtractor.
  - Set the quotient bit if the difference is non-negative and keep the difference; otherwise restore.
  - counter += 1. At counter==XLEN-1 on the edge, go to FIN (32 CALC edges: k+1..k+32).
- FIN: one edge (k+33 normal, k+1 fast path).
  - Sign fix-up: quotient is negated iff the operand signs differ; remainder takes the sign of the dividend. No fix-up for unsigned ops.
  - result is loaded, done=1, next state IDLE.
- Latency: done is high in the cycle after edge k+33 (normal) or k+1 (fast path).
- done: high for exactly one cycle, then low on the next edge. result is stable from that cycle until the next accepted start.
- start while busy: ignored, with no effect on operands or result.
- start in the done cycle: accepted (back-to-back issue allowed). done drops on that same edge.
- flush=1 at any edge: state=IDLE, busy=0, done=0. result is unchanged. flush has priority over start on the same edge.
- Operands are captured only at acceptance; rs1, rs2 and op may change freely while busy.
- Width rules:
  - Absolute value of 0x80000000 is held as unsigned 0x80000000.
  - The remainder register is XLEN+1 bits to hold the trial-subtract borrow.
  - Negation is two's complement modulo 2^XLEN.

Decomposition:
- Shared package (riscv_pkg): op encodings (OP_DIV, OP_DIVU, OP_REM, OP_REMU), state enum (IDLE, CALC, FIN), XLEN constant.
- Sub-module div_sign_fix: combinational. Takes quotient, remainder, sign flags and op; returns the final result. This isolates the fix-up logic for unit testing.
- The datapath and FSM stay in div_unit.

Test Plan:
- DIVU rs1=100, rs2=7, start at edge k -> busy 1 for 33 cycles; done pulse in the cycle after edge k+33; result=14. Repeat with REMU -> result=2.
- DIV rs1=0xFFFFFFF9 (-7), rs2=2 -> result=0xFFFFFFFD (-3). REM same operands -> result=0xFFFFFFFF (-1).
- Divide by zero: DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; done in the cycle after edge k+1.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0; fast-path latency.
- Start at edge k, second start with different operands at k+5 -> second start ignored; first result correct. Start again in the done cycle -> accepted; busy high on the next cycle.
- Abort cases:
  - flush at edge k+10 -> busy=0 on the next cycle, no done, previous result retained.
  - rst=0 at edge k+10 -> busy=0, done=0, result=0.
  - flush and start on the same edge while idle -> not accepted.
